regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file. Generalises the fixed 8-entry 2-read/1-write register file to configurable width, depth and port counts. Adds per-byte write enables, write-port conflict resolution, read-after-write bypass, optional registered reads, a hardware init sweep and out-of-range error reporting. Sits between datapath/sequencer logic and the external memory test harness as the CPU-style operand store.

Parameters:
DATA_W, 16, data width in bits; must be a multiple of 8
DEPTH, 8, number of registers; need not be a power of 2
ADDR_W, $clog2(DEPTH) (min 1), address width
NRD, 2, number of read ports
NWR, 1, number of write ports
RD_LAT, 0, read latency: 0 = combinational, 1 = registered
BYPASS, 1, 1 = a same-cycle write is visible on reads (RD_LAT=0 only)
INIT_VAL, 0, value written to every entry by the init sweep

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
clr  in  1  request a re-initialisation sweep
busy  out  1  high while the init sweep runs
we  in  NWR  write enable per write port
waddr  in  NWR*ADDR_W  write addresses, packed; port i at [i*ADDR_W +: ADDR_W]
wdata  in  NWR*DATA_W  write data, packed
wbe  in  NWR*(DATA_W/8)  byte enables per write port
raddr  in  NRD*ADDR_W  read addresses, packed
rdata  out  NRD*DATA_W  read data, packed
err  out  1  sticky out-of-range access flag

Behaviour:
- FSM states: INIT and READY. rst forces INIT with sweep pointer 0. busy=1 and err=0 on reset. With RD_LAT=1, registered rdata resets to INIT_VAL.
- INIT: each cycle writes INIT_VAL to entry[ptr], then ptr+1. After writing entry DEPTH-1, the next state is READY and busy drops. The sweep takes exactly DEPTH cycles after rst deasserts.
- In INIT, user writes are ignored and rdata returns INIT_VAL on every port.
- clr in READY enters INIT next cycle with ptr=0. clr during INIT restarts ptr at 0. rst mid-sweep also restarts the sweep.
- Write, in READY: for each byte lane b of entry a, the new value comes from the highest-index port i that satisfies we[i], waddr[i]==a and wbe[i][b]. If no port qualifies, the lane holds. The write commits at posedge.
- Out of range (addr >= DEPTH, with we asserted for writes, any cycle in READY for reads): the write is dropped, the read returns 0, and err sets and stays set until rst.
- Read, RD_LAT=0:
  - Combinational read of the array.
  - If BYPASS=1 and the same address is written this cycle, the merged write bytes are forwarded and the other bytes come from the array.
  - If BYPASS=0, the read returns the old value.
- Read, RD_LAT=1: rdata is registered and write-first. A read of an address written in the same cycle returns the merged new value one cycle later. BYPASS is ignored.
- Read ports are fully independent. Duplicate read addresses are legal.

Decomposition:
- Package regfile_pkg holds:
  - helper function for byte-lane count (DATA_W/8)
  - localparams for FSM state encoding (ST_INIT, ST_READY)
  - the address-width clamp function (min 1)
- One sub-module, regfile_wmerge: combinational per-entry byte-lane priority merge across write ports. It is reused for both the array update and the bypass path.

Test Plan:
1. Reset release, DEPTH=8 -> busy high for exactly 8 cycles, then low; all 8 entries read 0x0000; a write issued during busy is ignored.
2. NWR=2; port0 writes 0x1234 to reg3 with wbe=11, port1 writes 0xABCD to reg3 with wbe=01 in the same cycle -> reg3 = 0x12CD.
3. RD_LAT=0, BYPASS=1; write 0x00FF to reg5 while reading reg5 in the same cycle -> rdata=0x00FF in that cycle. With BYPASS=0 -> the old value, then 0x00FF next cycle.
4. RD_LAT=1; write 0x5A5A to reg2 and read reg2 in the same cycle -> rdata=0x5A5A one cycle later. Port1 simultaneously reads reg7 and gets its stored value.
5. DEPTH=5; write to addr 6 -> no entry changes, err=1 and stays 1. Read addr 7 -> 0x0000. err clears only on rst.
6. Fill all entries with nonzero values, pulse clr -> busy for 5 cycles, all entries read INIT_VAL. Assert rst mid-sweep -> the sweep restarts from entry 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    // Two-state controller: init sweep, then normal operation.
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Number of byte lanes in a data word.
    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

    // Address width for a given depth, never narrower than one bit.
    function automatic int addr_w_clamp(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the register file and its user: write ports,
// read ports, init control and status.
interface regfile_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NRD    = 2,
    parameter int NWR    = 1
);
    import regfile_pkg::*;

    localparam int NBE = byte_lanes(DATA_W);

    logic                    clr;
    logic                    busy;
    logic [NWR-1:0]          we;
    logic [NWR*ADDR_W-1:0]   waddr;
    logic [NWR*DATA_W-1:0]   wdata;
    logic [NWR*NBE-1:0]      wbe;
    logic [NRD*ADDR_W-1:0]   raddr;
    logic [NRD*DATA_W-1:0]   rdata;
    logic                    err;

    modport master (
        output clr, we, waddr, wdata, wbe, raddr,
        input  busy, rdata, err
    );

    modport slave (
        input  clr, we, waddr, wdata, wbe, raddr,
        output busy, rdata, err
    );

endinterface

// File: rtl/regfile_wmerge.sv
// Byte-lane priority merge of all write ports onto one entry. Lanes not
// written by any qualifying port keep old_data; among ports writing the
// same lane, the highest port index wins.
module regfile_wmerge
    import regfile_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NWR    = 1
) (
    input  logic [ADDR_W-1:0]                  addr,
    input  logic [DATA_W-1:0]                  old_data,
    input  logic [NWR-1:0]                     we,
    input  logic [NWR*ADDR_W-1:0]              waddr,
    input  logic [NWR*DATA_W-1:0]              wdata,
    input  logic [NWR*byte_lanes(DATA_W)-1:0]  wbe,
    output logic [DATA_W-1:0]                  new_data
);
    localparam int NBE = byte_lanes(DATA_W);

    // Walk ports in ascending order so later (higher) ports override lanes.
    always_comb begin
        // NOTE: defaulting every output first means no path leaves it unassigned, so no latch is inferred.
        new_data = old_data;
        for (int i = 0; i < NWR; i++) begin
            if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == addr)) begin
                for (int b = 0; b < NBE; b++) begin
                    if (wbe[i*NBE + b]) begin
                        new_data[b*8 +: 8] = wdata[i*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with byte enables, write-port
// priority, optional read-after-write bypass or registered reads, an
// init sweep after reset/clr, and a sticky out-of-range error flag.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 8,
    parameter int                ADDR_W   = addr_w_clamp(DEPTH),
    parameter int                NRD      = 2,
    parameter int                NWR      = 1,
    parameter int                RD_LAT   = 0,
    parameter int                BYPASS   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    // Depth widened by one bit so out-of-range addresses compare cleanly.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_e              state;
    logic [ADDR_W-1:0]   ptr;
    logic                busy_q;
    logic                err_q;
    logic [DATA_W-1:0]   mem      [DEPTH];
    logic [DATA_W-1:0]   mem_next [DEPTH];
    logic [DATA_W-1:0]   rd_val   [NRD];
    logic [NWR-1:0]      we_ok;
    logic                wr_oor;
    logic [NRD-1:0]      rd_bad;
    logic                rd_oor;

    // Keep only in-range writes issued while READY; flag the out-of-range ones.
    always_comb begin
        we_ok  = '0;
        wr_oor = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            if (bus.we[i] && (state == ST_READY)) begin
                if ({1'b0, bus.waddr[i*ADDR_W +: ADDR_W]} >= DEPTH_X) begin
                    wr_oor = 1'b1;
                end else begin
                    we_ok[i] = 1'b1;
                end
            end
        end
    end

    assign rd_oor = (state == ST_READY) && (|rd_bad);

    // Next value of every entry after this cycle's merged writes.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        regfile_wmerge #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NWR    (NWR)
        ) u_merge (
            .addr     (ADDR_W'(e)),
            .old_data (mem[e]),
            .we       (we_ok),
            .waddr    (bus.waddr),
            .wdata    (bus.wdata),
            .wbe      (bus.wbe),
            .new_data (mem_next[e])
        );
    end

    // Array update: sweep entry[ptr] during INIT, merged user writes in READY.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset term; the init sweep clears it so it can map onto plain RAM.
        if (!rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (state == ST_INIT) begin
                    if (ptr == ADDR_W'(e)) mem[e] <= INIT_VAL;
                end else begin
                    mem[e] <= mem_next[e];
                end
            end
        end
    end

    // Controller: sweep pointer, state, registered busy and sticky err.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every register samples the pre-edge values of the others.
        if (rst) begin
            state  <= ST_INIT;
            ptr    <= '0;
            busy_q <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            if (wr_oor || rd_oor) err_q <= 1'b1;
            case (state)
                ST_INIT: begin
                    if (bus.clr) begin
                        ptr <= '0;
                    end else if (ptr == LAST) begin
                        ptr    <= '0;
                        state  <= ST_READY;
                        busy_q <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ST_READY: begin
                    if (bus.clr) begin
                        ptr    <= '0;
                        state  <= ST_INIT;
                        busy_q <= 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Independent read ports; each has its own forwarding merge.
    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] ra_safe;
        logic              oor;
        logic [DATA_W-1:0] arr;
        logic [DATA_W-1:0] fwd;

        assign ra      = bus.raddr[r*ADDR_W +: ADDR_W];
        assign oor     = ({1'b0, ra} >= DEPTH_X);
        assign ra_safe = oor ? '0 : ra;
        assign arr     = mem[ra_safe];
        assign rd_bad[r] = oor;

        regfile_wmerge #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NWR    (NWR)
        ) u_fwd (
            .addr     (ra),
            .old_data (arr),
            .we       (we_ok),
            .waddr    (bus.waddr),
            .wdata    (bus.wdata),
            .wbe      (bus.wbe),
            .new_data (fwd)
        );

        if (RD_LAT == 0) begin : g_comb
            assign rd_val[r] = (state == ST_INIT) ? INIT_VAL :
                               oor                ? '0       :
                               (BYPASS != 0)      ? fwd      : arr;
        end else begin : g_reg
            logic [DATA_W-1:0] q;
            // Registered write-first read: capture the merged value of this cycle.
            always_ff @(posedge clk) begin
                if (rst)                    q <= INIT_VAL;
                else if (state == ST_INIT)  q <= INIT_VAL;
                else if (oor)               q <= '0;
                else                        q <= fwd;
            end
            assign rd_val[r] = q;
        end
    end

    // Pack per-port read values onto the bus.
    always_comb begin
        bus.rdata = '0;
        for (int r = 0; r < NRD; r++) begin
            bus.rdata[r*DATA_W +: DATA_W] = rd_val[r];
        end
    end

    assign bus.busy = busy_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp. Four configurations run side by side:
//   A: DEPTH 8, comb read, bypass     B: DEPTH 8, comb read, no bypass
//   C: DEPTH 8, registered read       D: DEPTH 5, comb read, bypass, INIT 0xC3C3
// Stimulus pushes expected values tagged with the cycle they are due;
// the monitor pops and compares them on the falling edge.
module tb_regfile_mp;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int IA = 0, IB = 1, IC = 2, ID = 3;
    localparam int K_RD0 = 0, K_RD1 = 1, K_BUSY = 2, K_ERR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared stimulus; D gets its own write enable and read addresses.
    logic [NW-1:0]    we_m, we_d;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NW*2-1:0]  wbe;
    logic [NR*AW-1:0] raddr_m, raddr_d;
    logic             clr;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) if_a ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) if_b ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) if_c ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) if_d ();

    assign if_a.clr = clr; assign if_a.we = we_m; assign if_a.waddr = waddr;
    assign if_a.wdata = wdata; assign if_a.wbe = wbe; assign if_a.raddr = raddr_m;
    assign if_b.clr = clr; assign if_b.we = we_m; assign if_b.waddr = waddr;
    assign if_b.wdata = wdata; assign if_b.wbe = wbe; assign if_b.raddr = raddr_m;
    assign if_c.clr = clr; assign if_c.we = we_m; assign if_c.waddr = waddr;
    assign if_c.wdata = wdata; assign if_c.wbe = wbe; assign if_c.raddr = raddr_m;
    assign if_d.clr = clr; assign if_d.we = we_d; assign if_d.waddr = waddr;
    assign if_d.wdata = wdata; assign if_d.wbe = wbe; assign if_d.raddr = raddr_d;

    regfile_mp #(.DATA_W(DW), .DEPTH(8), .NRD(NR), .NWR(NW), .RD_LAT(0), .BYPASS(1),
                 .INIT_VAL(16'h0000)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    regfile_mp #(.DATA_W(DW), .DEPTH(8), .NRD(NR), .NWR(NW), .RD_LAT(0), .BYPASS(0),
                 .INIT_VAL(16'h0000)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    regfile_mp #(.DATA_W(DW), .DEPTH(8), .NRD(NR), .NWR(NW), .RD_LAT(1), .BYPASS(1),
                 .INIT_VAL(16'h0000)) u_c (.clk(clk), .rst(rst), .bus(if_c));
    regfile_mp #(.DATA_W(DW), .DEPTH(5), .NRD(NR), .NWR(NW), .RD_LAT(0), .BYPASS(1),
                 .INIT_VAL(16'hC3C3)) u_d (.clk(clk), .rst(rst), .bus(if_d));

    logic [NR*DW-1:0] rd_v   [4];
    logic             busy_v [4];
    logic             err_v  [4];
    assign rd_v[0] = if_a.rdata; assign busy_v[0] = if_a.busy; assign err_v[0] = if_a.err;
    assign rd_v[1] = if_b.rdata; assign busy_v[1] = if_b.busy; assign err_v[1] = if_b.err;
    assign rd_v[2] = if_c.rdata; assign busy_v[2] = if_c.busy; assign err_v[2] = if_c.err;
    assign rd_v[3] = if_d.rdata; assign busy_v[3] = if_d.busy; assign err_v[3] = if_d.err;

    typedef struct {
        int          due;
        int          inst;
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push(input int inst, input int kind, input logic [15:0] exp,
                        input int dly, input string name);
        exp_t t;
        t.due  = cyc + dly;
        t.inst = inst;
        t.kind = kind;
        t.exp  = exp;
        t.name = name;
        sb.push_back(t);
    endtask

    function automatic logic [15:0] actual(input int inst, input int kind);
        logic [NR*DW-1:0] rv;
        rv = rd_v[inst];
        case (kind)
            K_RD0:   return rv[15:0];
            K_RD1:   return rv[31:16];
            K_BUSY:  return {15'd0, busy_v[inst]};
            default: return {15'd0, err_v[inst]};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
        waddr[AW-1:0] = a;
        wdata[15:0]   = d;
        wbe[1:0]      = be;
    endtask

    // Monitor: compare every expectation that falls due this cycle.
    initial begin
        int          i;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            i = 0;
            while (i < sb.size()) begin
                if (sb[i].due == cyc) begin
                    act = actual(sb[i].inst, sb[i].kind);
                    n_cmp++;
                    if (act !== sb[i].exp) begin
                        n_bad++;
                        $display("FAIL %s: got %h expected %h (cycle %0d)",
                                 sb[i].name, act, sb[i].exp, cyc);
                    end
                    sb.delete(i);
                end else if (sb[i].due < cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: never sampled, expected %h", sb[i].name, sb[i].exp);
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        we_m = '0; we_d = '0; clr = 1'b0;
        waddr = '0; wdata = '0; wbe = '0; raddr_m = '0; raddr_d = '0;
        rst = 1'b1;
        repeat (3) tick();

        // Reset release: busy for DEPTH cycles, write during busy ignored.
        rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            push(IA, K_BUSY, 16'(j < 8), 0, "busy_a_init");
            push(ID, K_BUSY, 16'(j < 5), 0, "busy_d_init");
            if (j == 0) begin
                push(IA, K_ERR, 16'h0000, 0, "err_a_reset");
                push(ID, K_ERR, 16'h0000, 0, "err_d_reset");
                push(ID, K_RD0, 16'hC3C3, 0, "d_read_during_init");
                push(IC, K_RD0, 16'h0000, 0, "c_reg_rdata_reset");
            end
            if (j == 2) begin
                we_m = 2'b01;
                wr0(3'd1, 16'hBEEF, 2'b11);
            end else begin
                we_m = 2'b00;
            end
            tick();
        end

        // All entries read zero after the sweep on both ports.
        for (int e = 0; e < 8; e++) begin
            raddr_m = {3'(7 - e), 3'(e)};
            push(IA, K_RD0, 16'h0000, 0, "a_after_init_p0");
            push(IA, K_RD1, 16'h0000, 0, "a_after_init_p1");
            push(IC, K_RD0, 16'h0000, 1, "c_after_init_p0");
            tick();
        end

        // Two write ports hit reg3: lane1 from port0, lane0 from port1.
        we_m    = 2'b11;
        waddr   = {3'd3, 3'd3};
        wdata   = {16'hABCD, 16'h1234};
        wbe     = {2'b01, 2'b11};
        raddr_m = {3'd0, 3'd3};
        push(IA, K_RD0, 16'h12CD, 0, "a_merge_bypass");
        push(IB, K_RD0, 16'h0000, 0, "b_merge_old");
        push(IC, K_RD0, 16'h12CD, 1, "c_merge_reg");
        tick();
        we_m = 2'b00;
        push(IA, K_RD0, 16'h12CD, 0, "a_reg3_stored");
        push(IB, K_RD0, 16'h12CD, 0, "b_reg3_stored");
        tick();

        // Read-after-write on reg5, full then upper-byte-only.
        we_m    = 2'b01;
        waddr   = {3'd0, 3'd5};
        wdata   = {16'h0000, 16'h00FF};
        wbe     = {2'b00, 2'b11};
        raddr_m = {3'd3, 3'd5};
        push(IA, K_RD0, 16'h00FF, 0, "a_raw_bypass");
        push(IA, K_RD1, 16'h12CD, 0, "a_port1_indep");
        push(IB, K_RD0, 16'h0000, 0, "b_raw_old");
        push(IC, K_RD0, 16'h00FF, 1, "c_raw_reg");
        push(IC, K_RD1, 16'h12CD, 1, "c_port1_reg");
        tick();
        wr0(3'd5, 16'h7700, 2'b10);
        push(IA, K_RD0, 16'h77FF, 0, "a_partial_bypass");
        push(IB, K_RD0, 16'h00FF, 0, "b_raw_next");
        push(IC, K_RD0, 16'h77FF, 1, "c_partial_reg");
        tick();
        we_m = 2'b00;
        push(IB, K_RD0, 16'h77FF, 0, "b_partial_stored");
        tick();

        // Registered read, write-first on reg2 while port1 reads reg7.
        we_m = 2'b01;
        wr0(3'd7, 16'h0707, 2'b11);
        tick();
        wr0(3'd2, 16'h5A5A, 2'b11);
        raddr_m = {3'd7, 3'd2};
        push(IC, K_RD0, 16'h5A5A, 1, "c_write_first");
        push(IC, K_RD1, 16'h0707, 1, "c_reg7_stored");
        push(IA, K_RD1, 16'h0707, 0, "a_reg7_stored");
        tick();
        we_m = 2'b00;
        tick();

        // DEPTH 5: fill, out-of-range write and read, sticky err.
        for (int e = 0; e < 5; e++) begin
            we_d = 2'b01;
            wr0(3'(e), 16'(16'h1111 * (e + 1)), 2'b11);
            tick();
        end
        wr0(3'd6, 16'hFFFF, 2'b11);
        push(ID, K_ERR, 16'h0000, 0, "d_err_before_oor");
        push(ID, K_ERR, 16'h0001, 1, "d_err_after_oor_wr");
        tick();
        we_d    = 2'b00;
        raddr_d = {3'd4, 3'd7};
        push(ID, K_RD0, 16'h0000, 0, "d_oor_read_zero");
        push(ID, K_RD1, 16'h5555, 0, "d_last_entry");
        push(IA, K_ERR, 16'h0000, 0, "a_err_clear");
        tick();
        for (int e = 0; e < 5; e++) begin
            raddr_d = {3'd0, 3'(e)};
            push(ID, K_RD0, 16'(16'h1111 * (e + 1)), 0, "d_entry_unchanged");
            push(ID, K_ERR, 16'h0001, 0, "d_err_sticky");
            tick();
        end

        // clr: DEPTH-cycle sweep back to INIT_VAL, err survives.
        clr = 1'b1;
        push(ID, K_BUSY, 16'h0000, 0, "d_busy_before_clr");
        tick();
        clr = 1'b0;
        for (int j = 0; j < 6; j++) begin
            push(ID, K_BUSY, 16'(j < 5), 0, "d_busy_clr");
            if (j < 5) push(ID, K_RD0, 16'hC3C3, 0, "d_read_during_clr");
            if (j == 5) push(ID, K_ERR, 16'h0001, 0, "d_err_survives_clr");
            tick();
        end
        repeat (2) tick();
        for (int e = 0; e < 5; e++) begin
            raddr_d = {3'd0, 3'(e)};
            raddr_m = {3'd0, 3'(e + 3)};
            push(ID, K_RD0, 16'hC3C3, 0, "d_entry_init_val");
            push(IA, K_RD0, 16'h0000, 0, "a_entry_cleared");
            tick();
        end

        // rst two cycles into a clr sweep restarts it from entry 0.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            push(ID, K_BUSY, 16'(j < 5), 0, "d_busy_rst_restart");
            if (j == 0) push(ID, K_ERR, 16'h0000, 0, "d_err_cleared_by_rst");
            tick();
        end
        repeat (2) tick();
        raddr_d = {3'd4, 3'd0};
        raddr_m = {3'd0, 3'd3};
        push(ID, K_RD0, 16'hC3C3, 0, "d_entry0_after_restart");
        push(ID, K_RD1, 16'hC3C3, 0, "d_entry4_after_restart");
        push(IA, K_BUSY, 16'h0000, 0, "a_ready_after_restart");
        push(IA, K_RD0, 16'h0000, 0, "a_reg3_after_restart");
        tick();
        repeat (2) tick();

        if (sb.size() != 0) begin
            n_cmp += sb.size();
            n_bad += sb.size();
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
